blur_frame_sequencer: RTL
=========================

// Module: blur_frame_sequencer
// PURPOSE
//  Sequences the blur_0 HLS core (ap_ctrl_hs) over one stored frame. For each pixel it
//  fetches the 96-bit neighbourhood word from the image block RAM and latches the 3x3 window.
//  It then runs one ap_start/ap_done transaction and presents the result on a valid/ready stream.
//  The stream goes to the VGA output stage. Sits between blk_mem_gen_0 port A and blur_0; owns both.
// PARAMETERS
//  NUM_PIX   18400  pixels per frame; addresses 0..NUM_PIX-1
//  ADDR_W    15     block RAM address width
//  BRAM_LAT  1      cycles from bram_addr change to valid bram_dout (1..3)
//  TIMEOUT   255    max cycles to wait for ap_ready or ap_done before aborting the pixel
// PORTS
//  clock       in   1        single clock for RAM, core and this block
//  reset       in   1        synchronous, active-high
//  frame_go    in   1        1-cycle pulse: process one full frame from address 0
//  abort       in   1        level: stop after the current core transaction, return to IDLE
//  bram_addr   out  ADDR_W   RAM read address (RAM write enable tied 0 outside this block)
//  bram_dout   in   96       RAM word: [95:24] = 9 bytes, window order below; [23:0] RGB, unused
//  win_pixels  out  72       latched window to core: {c,l,r,u,d,lu,ld,ru,rd}, MSB = c
//  ap_start    out  1        core start
//  ap_ready    in   1        core accepted inputs
//  ap_done     in   1        core result valid (single-cycle)
//  core_out    in   8        core out_pixel
//  out_valid   out  1        result available
//  out_ready   in   1        sink accepts result
//  out_pixel   out  8        blurred grey value
//  out_addr    out  ADDR_W   pixel index of out_pixel
//  busy        out  1        1 in every state except IDLE
//  frame_done  out  1        1-cycle pulse after the last pixel is accepted, or after an abort
//  timeout_err out  1        sticky; set on watchdog expiry, cleared by reset or frame_go
// BEHAVIOUR
//  Reset values:
//   - All outputs are 0; state is IDLE.
//   - Internal address, watchdog and latency counters are 0.
//  FSM states: IDLE, FETCH, LAUNCH, WAIT, EMIT.
//  IDLE
//   - On frame_go: pix := 0, bram_addr := 0, clear timeout_err, go to FETCH.
//   - frame_go while busy is ignored.
//  FETCH
//   - Count BRAM_LAT cycles.
//   - On the last count, latch win_pixels <= bram_dout[95:24] and go to LAUNCH.
//  LAUNCH
//   - ap_start = 1; win_pixels is held stable.
//   - On ap_ready=1, drop ap_start on the next cycle and go to WAIT.
//   - If ap_ready and ap_done are both high in the same cycle (combinational core), capture
//     core_out and go straight to EMIT.
//  WAIT
//   - ap_start = 0.
//   - On ap_done=1, out_pixel <= core_out, out_addr <= pix, go to EMIT.
//  EMIT
//   - out_valid = 1; out_pixel and out_addr are held until the out_valid&out_ready handshake.
//   - On the handshake:
//     - if pix == NUM_PIX-1 or abort=1: pulse frame_done, go to IDLE;
//     - else pix++, bram_addr = pix+1, go to FETCH.
//  Watchdog
//   - Counts cycles spent in LAUNCH+WAIT; it is reset on entering LAUNCH.
//   - On reaching TIMEOUT: set timeout_err, drop ap_start, emit out_pixel = 0 for that pixel,
//     and continue normally via EMIT.
//  abort
//   - Sampled only in EMIT and in FETCH.
//   - In FETCH: go directly to IDLE with a frame_done pulse.
//   - Never leaves the core mid-transaction.
//  Address wrap: bram_addr never exceeds NUM_PIX-1; the next frame restarts at 0.
//  Throughput: 1 + BRAM_LAT + core latency + 1 cycles per pixel when out_ready is held at 1.
//  Reset mid-frame: immediate return to IDLE with ap_start=0; no frame_done pulse.
// TESTING
//  1. Core model: ap_ready immediate, ap_done 3 cycles later, core_out = center byte;
//     RAM word for address k has c = k[7:0]; out_ready = 1; frame_go with NUM_PIX = 8
//     -> 8 results 0..7 on out_addr 0..7, frame_done one cycle after the 8th handshake,
//        then busy = 0.
//  2. Backpressure: out_ready = 0 for 5 cycles at pixel 2
//     -> out_valid stays 1, out_pixel/out_addr stable, no new bram_addr, no ap_start during the stall.
//  3. Core that never asserts ap_done, TIMEOUT = 10
//     -> ap_start deasserted, timeout_err = 1, out_pixel = 0 for that pixel, next pixel proceeds.
//  4. abort raised while in WAIT at pixel 4
//     -> pixel 4 still emitted, then frame_done pulse, IDLE, no fetch at address 5.
//  5. reset pulsed during LAUNCH
//     -> next cycle: ap_start = 0, out_valid = 0, busy = 0, no frame_done;
//        a following frame_go restarts at address 0.
//  6. frame_go pulsed while busy, plus a same-cycle ap_ready&ap_done core
//     -> frame_go ignored; the same-cycle result is captured and emitted correctly.

Source files
------------

// File: rtl/blur_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// blur_frame_sequencer_if
//
// Purpose:
//   Bundles the three buses that blur_frame_sequencer owns. These are the
//   image block RAM read port, the blur_0 ap_ctrl_hs core port and the
//   valid/ready result stream towards the VGA output stage.
//
// Signals:
//   bram_addr   RAM read address                       (sequencer -> RAM)
//   bram_dout   96-bit RAM word                        (RAM -> sequencer)
//   win_pixels  latched 3x3 window {c,l,r,u,d,lu,ld,ru,rd}
//                                                      (sequencer -> core)
//   ap_start    core start                             (sequencer -> core)
//   ap_ready    core accepted inputs                   (core -> sequencer)
//   ap_done     core result valid, single cycle        (core -> sequencer)
//   core_out    core out_pixel                         (core -> sequencer)
//   out_valid   result available                       (sequencer -> sink)
//   out_ready   sink accepts result                    (sink -> sequencer)
//   out_pixel   blurred grey value                     (sequencer -> sink)
//   out_addr    pixel index of out_pixel               (sequencer -> sink)
//
// Modports:
//   master  the sequencer side
//   slave   the environment side (RAM, core and sink)
// ---------------------------------------------------------------------------
interface blur_frame_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] bram_addr;
    logic [95:0]       bram_dout;
    logic [71:0]       win_pixels;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic [7:0]        core_out;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_pixel;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output bram_addr,
        input  bram_dout,
        output win_pixels,
        output ap_start,
        input  ap_ready,
        input  ap_done,
        input  core_out,
        output out_valid,
        input  out_ready,
        output out_pixel,
        output out_addr
    );

    modport slave (
        input  bram_addr,
        output bram_dout,
        input  win_pixels,
        input  ap_start,
        output ap_ready,
        output ap_done,
        output core_out,
        input  out_valid,
        output out_ready,
        input  out_pixel,
        input  out_addr
    );
endinterface

// File: rtl/blur_frame_sequencer.sv
// ---------------------------------------------------------------------------
// blur_frame_sequencer
//
// Purpose:
//   Walks the blur_0 HLS core (ap_ctrl_hs) over one stored frame. For every
//   pixel it performs these steps in order:
//     - read the 96-bit neighbourhood word from the image block RAM
//     - latch the 3x3 window
//     - run one ap_start/ap_done transaction
//     - present the result on a valid/ready stream for the VGA output stage
//   A watchdog keeps a stuck core from hanging the frame. A timed-out pixel is
//   emitted as 0 and the sticky timeout_err flag is raised.
//
// Parameters:
//   NUM_PIX   pixels per frame, addresses 0..NUM_PIX-1
//   ADDR_W    block RAM address width
//   BRAM_LAT  cycles from a bram_addr change to valid bram_dout (1..3)
//   TIMEOUT   max cycles spent in LAUNCH+WAIT before the pixel is abandoned
//
// Ports:
//   clock        single clock for RAM, core and this block
//   reset        synchronous, active-high
//   frame_go     1-cycle pulse, start a frame at address 0 (ignored when busy)
//   abort        level, stop at the next safe point (FETCH or EMIT handshake)
//   bus          blur_frame_sequencer_if.master (RAM, core and result stream)
//   busy         high in every state except IDLE
//   frame_done   1-cycle pulse after the last accepted pixel or after an abort
//   timeout_err  sticky watchdog flag, cleared by reset or an accepted frame_go
// ---------------------------------------------------------------------------
module blur_frame_sequencer #(
    parameter int NUM_PIX  = 18400,
    parameter int ADDR_W   = 15,
    parameter int BRAM_LAT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_go,
    input  logic abort,
    blur_frame_sequencer_if.master bus,
    output logic busy,
    output logic frame_done,
    output logic timeout_err
);

    localparam int LAT_W = $clog2(BRAM_LAT + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(BRAM_LAT);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        WAIT,
        EMIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] pix;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [71:0]       win_q;
    logic [7:0]        out_pixel_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              frame_done_q;
    logic              timeout_err_q;

    // Single-cycle strobes from the FSM to the datapath.
    logic start_frame;
    logic latch_win;
    logic lat_inc;
    logic wd_inc;
    logic core_capture;
    logic wd_expire;
    logic pix_advance;
    logic end_frame;

    logic ap_start_c;
    logic out_valid_c;
    logic busy_c;

    // The RGB part of the RAM word belongs to another consumer.
    logic [23:0] unused_rgb;
    assign unused_rgb = bus.bram_dout[23:0];

    // State register. A mid-frame reset drops straight back to IDLE and does
    // not produce a frame_done pulse, because frame_done_q is also cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the Moore outputs. The datapath below only reacts
    // to the strobes raised here, so every decision lives in this block.
    // The watchdog is tested after ap_ready/ap_done. A core that answers in
    // the last allowed cycle therefore still gets its result through.
    always_comb begin
        next_state   = state;
        start_frame  = 1'b0;
        latch_win    = 1'b0;
        lat_inc      = 1'b0;
        wd_inc       = 1'b0;
        core_capture = 1'b0;
        wd_expire    = 1'b0;
        pix_advance  = 1'b0;
        end_frame    = 1'b0;
        ap_start_c   = 1'b0;
        out_valid_c  = 1'b0;
        busy_c       = 1'b1;

        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (frame_go) begin
                    start_frame = 1'b1;
                    next_state  = FETCH;
                end
            end

            FETCH: begin
                if (abort) begin
                    end_frame  = 1'b1;
                    next_state = IDLE;
                end else if (lat_cnt == LAT_LAST) begin
                    latch_win  = 1'b1;
                    next_state = LAUNCH;
                end else begin
                    lat_inc = 1'b1;
                end
            end

            LAUNCH: begin
                ap_start_c = 1'b1;
                if (bus.ap_ready && bus.ap_done) begin
                    core_capture = 1'b1;
                    next_state   = EMIT;
                end else if (bus.ap_ready) begin
                    wd_inc     = 1'b1;
                    next_state = WAIT;
                end else if (wd_cnt >= WD_LAST) begin
                    wd_expire  = 1'b1;
                    next_state = EMIT;
                end else begin
                    wd_inc = 1'b1;
                end
            end

            WAIT: begin
                if (bus.ap_done) begin
                    core_capture = 1'b1;
                    next_state   = EMIT;
                end else if (wd_cnt >= WD_LAST) begin
                    wd_expire  = 1'b1;
                    next_state = EMIT;
                end else begin
                    wd_inc = 1'b1;
                end
            end

            EMIT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    if ((pix == LAST_PIX) || abort) begin
                        end_frame  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        pix_advance = 1'b1;
                        next_state  = FETCH;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. The FETCH counter runs from 0 to BRAM_LAT, which
    // is BRAM_LAT+1 cycles. The first cycle is the one where the freshly
    // registered address reaches the RAM. The RAM word is sampled only after
    // that address has been in place for a full BRAM_LAT cycles.
    // pix only advances while it is below LAST_PIX. This keeps bram_addr
    // inside the frame. The address is also returned to 0 on every frame end.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix           <= '0;
            bram_addr_q   <= '0;
            lat_cnt       <= '0;
            wd_cnt        <= '0;
            win_q         <= '0;
            out_pixel_q   <= '0;
            out_addr_q    <= '0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            frame_done_q <= end_frame;

            if (start_frame) begin
                pix           <= '0;
                bram_addr_q   <= '0;
                lat_cnt       <= '0;
                timeout_err_q <= 1'b0;
            end

            if (lat_inc) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            if (latch_win) begin
                win_q  <= bus.bram_dout[95:24];
                wd_cnt <= '0;
            end

            if (wd_inc) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (core_capture) begin
                out_pixel_q <= bus.core_out;
                out_addr_q  <= pix;
            end

            if (wd_expire) begin
                out_pixel_q   <= '0;
                out_addr_q    <= pix;
                timeout_err_q <= 1'b1;
            end

            if (pix_advance) begin
                pix         <= pix + ADDR_W'(1);
                bram_addr_q <= pix + ADDR_W'(1);
                lat_cnt     <= '0;
            end

            if (end_frame) begin
                bram_addr_q <= '0;
                lat_cnt     <= '0;
                wd_cnt      <= '0;
            end
        end
    end

    assign bus.bram_addr  = bram_addr_q;
    assign bus.win_pixels = win_q;
    assign bus.ap_start   = ap_start_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_pixel  = out_pixel_q;
    assign bus.out_addr   = out_addr_q;
    assign busy           = busy_c;
    assign frame_done     = frame_done_q;
    assign timeout_err    = timeout_err_q;

endmodule
